// File: rtl/step_motor_pkg.sv
// Shared step/dir motor types and default widths, common to the driver and the receiver.
package step_motor_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } filt_state_t;

    localparam logic DIR_POS = 1'b1;

    localparam int STEP_NUMBER_WIDTH = 16;
    localparam int SPEED_WIDTH       = 16;

endpackage

// File: rtl/step_input_filter.sv
// 2-FF synchronisers for drive/dir/xen plus the drive-line glitch filter.
// With STEP_PULSE_DECODER_DIR_ERR_EN defined, also reports when a pulse is in progress.
module step_input_filter
    import step_motor_pkg::*;
#(
    parameter int C_FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic drive,
    input  logic dir,
    input  logic xen,
    output logic step_evt,
    output logic dir_sync,
    output logic xen_sync
`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    ,
    output logic in_pulse
`endif
);

    localparam logic [3:0] LEN = 4'(C_FILTER_LEN);

    logic drive_p0, drive_p1;
    logic dir_p0, dir_p1;
    logic xen_p0, xen_p1;

    filt_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Synchroniser stage: p1 is the first value safe to use
    always_ff @(posedge clk) begin
        if (reset) begin
            drive_p0 <= 1'b0;
            drive_p1 <= 1'b0;
            dir_p0   <= 1'b0;
            dir_p1   <= 1'b0;
            xen_p0   <= 1'b0;
            xen_p1   <= 1'b0;
        end else begin
            drive_p0 <= drive;
            drive_p1 <= drive_p0;
            dir_p0   <= dir;
            dir_p1   <= dir_p0;
            xen_p0   <= xen;
            xen_p1   <= xen_p0;
        end
    end

    assign dir_sync = dir_p1;
    assign xen_sync = xen_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOW;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Filter stage: a level must persist for LEN strobes to be accepted
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_evt  = 1'b0;
        if (clk_en) begin
            case (state)
                LOW: begin
                    if (drive_p1) begin
                        if (LEN == 4'd1) begin
                            state_nxt = HIGH;
                            step_evt  = 1'b1;
                        end else begin
                            state_nxt = RISE_CHK;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                RISE_CHK: begin
                    if (drive_p1) begin
                        cnt_nxt = cnt + 4'd1;
                        if ((cnt + 4'd1) == LEN) begin
                            state_nxt = HIGH;
                            step_evt  = 1'b1;
                        end
                    end else begin
                        state_nxt = LOW;
                    end
                end
                HIGH: begin
                    if (!drive_p1) begin
                        if (LEN == 4'd1) begin
                            state_nxt = LOW;
                        end else begin
                            state_nxt = FALL_CHK;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                FALL_CHK: begin
                    if (!drive_p1) begin
                        cnt_nxt = cnt + 4'd1;
                        if ((cnt + 4'd1) == LEN) begin
                            state_nxt = LOW;
                        end
                    end else begin
                        state_nxt = HIGH;
                    end
                end
                default: state_nxt = LOW;
            endcase
        end
    end

`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    assign in_pulse = (state != LOW);
`endif

endmodule

// File: rtl/step_pulse_decoder.sv
// Step/dir receiver: counts filtered steps into position/relative counters, measures period,
// flags done and stall. Optional dir setup/hold checker under STEP_PULSE_DECODER_DIR_ERR_EN.
module step_pulse_decoder
    import step_motor_pkg::*;
#(
    parameter int C_POS_WIDTH         = 32,
    parameter int C_STEP_NUMBER_WIDTH = STEP_NUMBER_WIDTH,
    parameter int C_PERIOD_WIDTH      = SPEED_WIDTH,
    parameter int C_FILTER_LEN        = 3,
    parameter logic [C_PERIOD_WIDTH-1:0] C_STALL_TICKS = 16'hFFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_clk_en,
    input  logic                           i_drive,
    input  logic                           i_dir,
    input  logic                           i_xen,
    input  logic                           i_arm,
    input  logic [C_STEP_NUMBER_WIDTH-1:0] i_target,
    input  logic                           i_pos_clr,
    output logic signed [C_POS_WIDTH-1:0]  o_position,
    output logic [C_STEP_NUMBER_WIDTH-1:0] o_rel_steps,
    output logic [C_PERIOD_WIDTH-1:0]      o_period,
    output logic                           o_period_vld,
    output logic                           o_done,
    output logic                           o_stall,
`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    output logic                           o_dir_err,
`endif
    output logic                           o_interrupt
);

    localparam logic signed [C_POS_WIDTH-1:0] POS_ONE = C_POS_WIDTH'(1);

    function automatic logic [C_STEP_NUMBER_WIDTH-1:0] sat_inc_steps(
        input logic [C_STEP_NUMBER_WIDTH-1:0] v);
        return (&v) ? v : v + C_STEP_NUMBER_WIDTH'(1);
    endfunction

    function automatic logic [C_PERIOD_WIDTH-1:0] sat_inc_period(
        input logic [C_PERIOD_WIDTH-1:0] v);
        return (&v) ? v : v + C_PERIOD_WIDTH'(1);
    endfunction

    logic step_evt, dir_sync, xen_sync;
    logic [C_STEP_NUMBER_WIDTH-1:0] target;
    logic [C_PERIOD_WIDTH-1:0]      period_cnt;
    logic armed, have_ref, stall_hit, step_ok;

`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    logic in_pulse;
`endif

    step_input_filter #(
        .C_FILTER_LEN (C_FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (i_clk_en),
        .drive    (i_drive),
        .dir      (i_dir),
        .xen      (i_xen),
        .step_evt (step_evt),
        .dir_sync (dir_sync),
`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
        .in_pulse (in_pulse),
`endif
        .xen_sync (xen_sync)
    );

    assign step_ok   = step_evt && xen_sync;
    assign stall_hit = i_clk_en && armed && !o_done && xen_sync && (period_cnt >= C_STALL_TICKS);

    // Accounting stage: all results registered one clk after the filtered event
    always_ff @(posedge clk) begin
        if (reset) begin
            o_position   <= '0;
            o_rel_steps  <= '0;
            o_period     <= '0;
            o_period_vld <= 1'b0;
            o_done       <= 1'b0;
            o_stall      <= 1'b0;
            target       <= '0;
            period_cnt   <= '0;
            armed        <= 1'b0;
            have_ref     <= 1'b0;
        end else begin
            o_period_vld <= 1'b0;

            // A clear coincident with a step drops that step entirely
            if (i_pos_clr) begin
                o_position <= '0;
            end else if (step_ok) begin
                o_position <= (dir_sync == DIR_POS) ? o_position + POS_ONE
                                                    : o_position - POS_ONE;
            end

            if (i_arm) begin
                o_rel_steps <= '0;
                target      <= i_target;
                armed       <= 1'b1;
                o_done      <= 1'b0;
                o_stall     <= 1'b0;
                have_ref    <= 1'b0;
            end else begin
                if (step_ok && !i_pos_clr) begin
                    o_rel_steps <= sat_inc_steps(o_rel_steps);
                end
                if (armed && (o_rel_steps == target)) begin
                    o_done <= 1'b1;
                end
                if (stall_hit) begin
                    o_stall <= 1'b1;
                end
                if (step_evt) begin
                    have_ref <= 1'b1;
                end
            end

            if (i_arm) begin
                period_cnt <= '0;
            end else if (i_clk_en) begin
                period_cnt <= step_evt ? C_PERIOD_WIDTH'(1) : sat_inc_period(period_cnt);
            end

            if (step_evt) begin
                o_period     <= period_cnt;
                o_period_vld <= have_ref && !i_arm;
            end
        end
    end

`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    logic dir_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_prev  <= 1'b0;
            o_dir_err <= 1'b0;
        end else begin
            dir_prev <= dir_sync;
            if (i_arm) begin
                o_dir_err <= 1'b0;
            end else if (in_pulse && (dir_sync != dir_prev)) begin
                o_dir_err <= 1'b1;
            end
        end
    end

    assign o_interrupt = o_done | o_stall | o_dir_err;
`else
    assign o_interrupt = o_done | o_stall;
`endif

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Directed bench for step_pulse_decoder (C_FILTER_LEN = 3, C_STALL_TICKS = 100).
module tb_step_pulse_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        drive = 1'b0;
    logic        dir = 1'b0;
    logic        xen = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] target = 16'd0;
    logic        pos_clr = 1'b0;
    logic [31:0] position;
    logic [15:0] rel_steps;
    logic [15:0] period;
    logic        period_vld;
    logic        done;
    logic        stall;
    logic        interrupt;
`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
    logic        dir_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int vld_cnt  = 0;

    always #5 clk = ~clk;

    step_pulse_decoder #(
        .C_POS_WIDTH         (32),
        .C_STEP_NUMBER_WIDTH (16),
        .C_PERIOD_WIDTH      (16),
        .C_FILTER_LEN        (3),
        .C_STALL_TICKS       (16'd100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_clk_en     (clk_en),
        .i_drive      (drive),
        .i_dir        (dir),
        .i_xen        (xen),
        .i_arm        (arm),
        .i_target     (target),
        .i_pos_clr    (pos_clr),
        .o_position   (position),
        .o_rel_steps  (rel_steps),
        .o_period     (period),
        .o_period_vld (period_vld),
        .o_done       (done),
        .o_stall      (stall),
`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
        .o_dir_err    (dir_err),
`endif
        .o_interrupt  (interrupt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    // One sample strobe every 4 clks; clr/arm ride on the strobe cycle itself.
    task automatic tick1(input logic clr, input logic arm_f);
        repeat (3) @(posedge clk);
        #1;
        clk_en  = 1'b1;
        pos_clr = clr;
        arm     = arm_f;
        @(posedge clk);
        #1;
        clk_en  = 1'b0;
        pos_clr = 1'b0;
        arm     = 1'b0;
        if (period_vld) vld_cnt++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) tick1(1'b0, 1'b0);
    endtask

    task automatic pulse(input int hi, input int lo);
        drive = 1'b1;
        tick(hi);
        drive = 1'b0;
        tick(lo);
    endtask

    task automatic arm_pulse(input logic [15:0] tgt);
        target = tgt;
        arm    = 1'b1;
        @(posedge clk);
        #1;
        arm    = 1'b0;
    endtask

    task automatic clr_pulse();
        pos_clr = 1'b1;
        @(posedge clk);
        #1;
        pos_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_position", position, 32'd0);
        check("rst_rel", {16'd0, rel_steps}, 32'd0);
        check("rst_period", {16'd0, period}, 32'd0);
        check("rst_vld", {31'd0, period_vld}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);
        reset = 1'b0;
        xen = 1'b1;
        dir = 1'b1;
        tick(2);

        // Clean pulses
        arm_pulse(16'd5);
        vld_cnt = 0;
        for (int i = 0; i < 5; i++) pulse(8, 8);
        check("clean_position", position, 32'd5);
        check("clean_rel", {16'd0, rel_steps}, 32'd5);
        check("clean_period", {16'd0, period}, 32'd16);
        check("clean_vld_count", vld_cnt, 32'd4);
        check("clean_done", {31'd0, done}, 32'd1);
        check("clean_irq", {31'd0, interrupt}, 32'd1);
        check("clean_stall", {31'd0, stall}, 32'd0);

        // Glitch rejection
        arm_pulse(16'd10);
        clr_pulse();
        pulse(2, 4);
        pulse(2, 4);
        pulse(3, 4);
        check("glitch_rel", {16'd0, rel_steps}, 32'd1);
        check("glitch_position", position, 32'd1);
        check("glitch_done", {31'd0, done}, 32'd0);

        // Direction
        clr_pulse();
        arm_pulse(16'd20);
        for (int i = 0; i < 4; i++) pulse(4, 4);
        dir = 1'b0;
        for (int i = 0; i < 6; i++) pulse(4, 4);
        check("dir_position", position, 32'hFFFF_FFFE);
        check("dir_rel", {16'd0, rel_steps}, 32'd10);
        check("dir_period", {16'd0, period}, 32'd8);

        // Stall: flagged on the 100th strobe after the second step
        dir = 1'b1;
        tick(2);
        arm_pulse(16'd10);
        pulse(4, 4);
        drive = 1'b1;
        tick(3);
        drive = 1'b0;
        tick(99);
        check("stall_early", {31'd0, stall}, 32'd0);
        tick(1);
        check("stall_set", {31'd0, stall}, 32'd1);
        check("stall_irq", {31'd0, interrupt}, 32'd1);
        check("stall_position", position, 32'd0);
        arm_pulse(16'd10);
        check("stall_arm_clear", {31'd0, stall}, 32'd0);

        // xen low: steps ignored
        xen = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) pulse(4, 4);
        check("xen_rel", {16'd0, rel_steps}, 32'd0);
        check("xen_position", position, 32'd0);
        xen = 1'b1;
        tick(2);

        // pos_clr coincident with the step strobe
        pulse(4, 4);
        check("pre_clr_position", position, 32'd1);
        drive = 1'b1;
        tick(2);
        tick1(1'b1, 1'b0);
        check("clr_evt_position", position, 32'd0);
        check("clr_evt_rel", {16'd0, rel_steps}, 32'd1);
        tick(1);
        drive = 1'b0;
        tick(4);

        // arm coincident with the step strobe
        pulse(4, 4);
        check("pre_arm_rel", {16'd0, rel_steps}, 32'd2);
        target = 16'd10;
        drive = 1'b1;
        tick(2);
        tick1(1'b0, 1'b1);
        check("arm_evt_rel", {16'd0, rel_steps}, 32'd0);
        check("arm_evt_position", position, 32'd2);
        tick(1);
        drive = 1'b0;
        tick(4);

        // Reset mid-pulse
        drive = 1'b1;
        tick(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_position", position, 32'd0);
        check("midrst_period", {16'd0, period}, 32'd0);
        check("midrst_rel", {16'd0, rel_steps}, 32'd0);
        check("midrst_irq", {31'd0, interrupt}, 32'd0);
        reset = 1'b0;
        tick(1);
        drive = 1'b0;
        tick(4);
        check("postrst_position", position, 32'd0);

        // target = 0 completes right after arm
        arm_pulse(16'd0);
        @(posedge clk);
        #1;
        check("zero_tgt_done", {31'd0, done}, 32'd1);
        check("zero_tgt_irq", {31'd0, interrupt}, 32'd1);

`ifdef STEP_PULSE_DECODER_DIR_ERR_EN
        arm_pulse(16'd10);
        check("direrr_cleared", {31'd0, dir_err}, 32'd0);
        drive = 1'b1;
        tick(4);
        dir = 1'b0;
        tick(2);
        drive = 1'b0;
        tick(4);
        check("direrr_set", {31'd0, dir_err}, 32'd1);
        check("direrr_irq", {31'd0, interrupt}, 32'd1);
        arm_pulse(16'd10);
        check("direrr_arm_clear", {31'd0, dir_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
